bootram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 8 KB boot RAM (the 4×2Kx8 byte-lane SRAM wrapper). It shares the RAM between the CPU memory port (m0) and the boot loader/debug write port (m1), one transaction at a time. It drives the wrapper's `mem_s_valid`/`mem_s_ready` pair so that the SRAM chip enable asserts for exactly one cycle per access. It returns ready and read data to the granted master two cycles after grant.

---
 rtl/bootram_arb_pkg.sv | 33 +++
 rtl/bootram_rr_arb2.sv | 34 +++
 rtl/bootram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bootram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootram_arb_pkg.sv
// Shared definitions for the boot RAM arbiter slice.
//
// Contents:
//   arb_state_e        - sequencer states (IDLE / ACCESS / RESP)
//   PORT_CPU/PORT_LDR  - master indices used for grant and last_grant
//   ADDR_BITS_DEFAULT  - byte-address width of the 8 KB boot RAM
//   addr_mask()        - builds the mask that clears address bits above the RAM
package bootram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int ADDR_BITS_DEFAULT = 13;

  // Keeps the low 'bits' address bits and zeroes the rest; a full 32-bit
  // width passes the address through untouched.
  function automatic logic [31:0] addr_mask(input int bits);
    logic [31:0] m;
    if (bits >= 32) begin
      m = '1;
    end else begin
      m = (32'd1 << bits) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bootram_rr_arb2.sv
// Combinational two-request arbiter for the boot RAM sequencer.
//
// Ports:
//   req0_i       - eligible request from the CPU port (m0)
//   req1_i       - eligible request from the loader port (m1)
//   last_grant_i - master that won the previous grant
//   rr_en_i      - 1 = round-robin tie-break, 0 = loader always wins ties
//   winner_o     - index of the winning master (valid with gnt_valid_o)
//   gnt_valid_o  - at least one request is eligible
module bootram_rr_arb2
  import bootram_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  input  logic rr_en_i,
  output logic winner_o,
  output logic gnt_valid_o
);

  // A lone request always wins; only a tie consults the policy. Under
  // round-robin the master that did not win last time goes first, which
  // bounds the wait of either side to one transaction.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    winner_o    = PORT_CPU;
    if (req0_i && req1_i) begin
      winner_o = rr_en_i ? ~last_grant_i : PORT_LDR;
    end else if (req1_i) begin
      winner_o = PORT_LDR;
    end
  end

endmodule

// File: rtl/bootram_arbiter.sv
// Two-port arbiter and access sequencer for the 8 KB boot RAM wrapper.
// Serialises CPU (m0) and loader/debug (m1) transactions so that the SRAM
// chip enable (mem_s_valid & ~mem_s_ready) is high for exactly one cycle per
// access, and returns ready/rdata to the granted master two cycles after grant.
//
// Parameters:
//   ADDR_BITS - byte-address width forwarded to the RAM; higher bits are zeroed
//   ARB_RR    - 1 = round-robin between m0 and m1, 0 = m1 has fixed priority
//
// Ports:
//   clk_i, reset_i          - clock, synchronous active-high reset
//   cpu_hold_i              - blocks new grants to m0 (loader programming phase)
//   m0_* / m1_*             - master request ports (valid/addr/wdata/wstrb in,
//                             ready/rdata out); wstrb == 0 means read
//   mem_s_valid_o/ready_o   - handshake pair driving the wrapper's chip enable
//   mem_s_addr/wdata/wstrb_o- access fields to the wrapper
//   mem_s_rdata_i           - wrapper read data, valid the cycle after chip enable
//   grant_o                 - current or most recent owner (0 = m0, 1 = m1)
//   busy_o                  - a transaction is in ACCESS or RESP
module bootram_arbiter
  import bootram_arb_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter bit ARB_RR    = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_hold_i,

  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,

  output logic        mem_s_valid_o,
  output logic        mem_s_ready_o,
  output logic [31:0] mem_s_addr_o,
  output logic [31:0] mem_s_wdata_o,
  output logic [3:0]  mem_s_wstrb_o,
  input  logic [31:0] mem_s_rdata_i,

  output logic        grant_o,
  output logic        busy_o
);

  localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_BITS);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req0, req1;
  logic        winner, gnt_valid;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  // cpu_hold only gates eligibility; a grant already made is unaffected.
  assign req0 = m0_valid_i & ~cpu_hold_i;
  assign req1 = m1_valid_i;

  bootram_rr_arb2 u_arb (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant_q),
    .rr_en_i      (ARB_RR),
    .winner_o     (winner),
    .gnt_valid_o  (gnt_valid)
  );

  // The master mux follows the registered grant, so it cannot switch
  // between ACCESS and RESP even if the other master starts requesting.
  assign sel_addr  = (grant_q ? m1_addr_i : m0_addr_i) & ADDR_MASK;
  assign sel_wdata = grant_q ? m1_wdata_i : m0_wdata_i;
  assign sel_wstrb = grant_q ? m1_wstrb_i : m0_wstrb_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  // Next-state and output decode. addr/wdata are captured during ACCESS so
  // the wrapper sees them held through RESP and IDLE; wstrb is only driven
  // in ACCESS so a write can never be repeated in the RESP cycle.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;

    mem_s_valid_o = 1'b0;
    mem_s_ready_o = 1'b0;
    mem_s_addr_o  = addr_q;
    mem_s_wdata_o = wdata_q;
    mem_s_wstrb_o = 4'b0000;
    m0_ready_o    = 1'b0;
    m0_rdata_o    = 32'h0;
    m1_ready_o    = 1'b0;
    m1_rdata_o    = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        mem_s_valid_o = 1'b1;
        mem_s_addr_o  = sel_addr;
        mem_s_wdata_o = sel_wdata;
        mem_s_wstrb_o = sel_wstrb;
        addr_d        = sel_addr;
        wdata_d       = sel_wdata;
        state_d       = RESP;
      end

      RESP: begin
        // valid & ready together drop the chip enable while the wrapper's
        // registered read data is handed back to the owner.
        mem_s_valid_o = 1'b1;
        mem_s_ready_o = 1'b1;
        if (grant_q == PORT_LDR) begin
          m1_ready_o = 1'b1;
          m1_rdata_o = mem_s_rdata_i;
        end else begin
          m0_ready_o = 1'b1;
          m0_rdata_o = mem_s_rdata_i;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to the loader so the very first tie under
  // round-robin goes to the CPU.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= PORT_CPU;
      last_grant_q <= PORT_LDR;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bootram_arbiter.sv
// Directed testbench for bootram_arbiter. A behavioural 2Kx32 byte-lane RAM
// stands in for the SRAM wrapper of the round-robin instance; a second,
// fixed-priority instance shares the same master inputs for arbitration checks.
module tb_bootram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_hold;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_s_valid, mem_s_ready;
  logic [31:0] mem_s_addr, mem_s_wdata, mem_s_rdata;
  logic [3:0]  mem_s_wstrb;
  logic        grant, busy;

  logic        fp_m0_ready, fp_m1_ready;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_mem_s_valid, fp_mem_s_ready;
  logic [31:0] fp_mem_s_addr, fp_mem_s_wdata;
  logic [3:0]  fp_mem_s_wstrb;
  logic        fp_grant, fp_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram [0:2047];
  logic        preload_en = 1'b0;
  logic [10:0] preload_idx = '0;
  logic [31:0] preload_data = '0;
  logic        ce;
  int          ce_count = 0;

  always #5 clk = ~clk;

  bootram_arbiter #(.ADDR_BITS(13), .ARB_RR(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .cpu_hold_i(cpu_hold),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata),
    .mem_s_valid_o(mem_s_valid), .mem_s_ready_o(mem_s_ready),
    .mem_s_addr_o(mem_s_addr), .mem_s_wdata_o(mem_s_wdata),
    .mem_s_wstrb_o(mem_s_wstrb), .mem_s_rdata_i(mem_s_rdata),
    .grant_o(grant), .busy_o(busy)
  );

  bootram_arbiter #(.ADDR_BITS(13), .ARB_RR(1'b0)) dut_fp (
    .clk_i(clk), .reset_i(reset), .cpu_hold_i(cpu_hold),
    .m0_valid_i(m0_valid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_ready_o(fp_m0_ready), .m0_rdata_o(fp_m0_rdata),
    .m1_valid_i(m1_valid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_ready_o(fp_m1_ready), .m1_rdata_o(fp_m1_rdata),
    .mem_s_valid_o(fp_mem_s_valid), .mem_s_ready_o(fp_mem_s_ready),
    .mem_s_addr_o(fp_mem_s_addr), .mem_s_wdata_o(fp_mem_s_wdata),
    .mem_s_wstrb_o(fp_mem_s_wstrb), .mem_s_rdata_i(32'h0),
    .grant_o(fp_grant), .busy_o(fp_busy)
  );

  // Wrapper model: chip enable writes strobed lanes and registers the
  // (pre-write) word, which becomes valid the cycle after chip enable.
  assign ce = mem_s_valid & ~mem_s_ready;

  always @(posedge clk) begin
    if (preload_en) begin
      ram[preload_idx] <= preload_data;
    end else if (ce) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_s_wstrb[b]) ram[mem_s_addr[12:2]][8*b +: 8] <= mem_s_wdata[8*b +: 8];
      end
      mem_s_rdata <= ram[mem_s_addr[12:2]];
    end
  end

  always @(posedge clk) begin
    if (ce) ce_count <= ce_count + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] data);
    preload_idx  = idx;
    preload_data = data;
    preload_en   = 1'b1;
    tick();
    preload_en   = 1'b0;
  endtask

  task automatic idle_inputs;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  // Issues one transaction and waits (bounded) for its ready pulse.
  // lat is the number of clock edges from request to ready, -1 on timeout.
  task automatic run_txn(input logic port, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         output logic [31:0] rdata, output int lat);
    lat   = -1;
    rdata = 'x;
    if (port) begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (port ? m1_ready : m0_ready) begin
        lat   = i;
        rdata = port ? m1_rdata : m0_rdata;
        break;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_hold = 1'b0; idle_inputs();
    tick(); tick();
    vectors++;
    if ({grant, busy, mem_s_valid, mem_s_ready, m0_ready, m1_ready} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {grant, busy, mem_s_valid, mem_s_ready, m0_ready, m1_ready});
    end
    vectors++;
    if ({mem_s_addr, mem_s_wdata} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_s_addr, mem_s_wdata);
    end
    vectors++;
    if ({mem_s_wstrb, m0_rdata, m1_rdata} !== 68'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_wstrb_rdata: got %h/%h/%h expected 0", mem_s_wstrb, m0_rdata, m1_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_m0_read;
    int c0;
    preload(11'h41, 32'hDEADBEEF);
    c0 = ce_count;
    m0_addr = 32'h0000_0104; m0_wstrb = 4'b0000; m0_valid = 1'b1;
    tick();
    vectors++;
    if ({ce, grant, mem_s_addr} !== {1'b1, 1'b0, 32'h0000_0104}) begin
      miscompares++;
      $display("[TB] FAIL m0rd_access: got ce=%b grant=%b addr=%h expected 1 0 00000104", ce, grant, mem_s_addr);
    end
    tick();
    vectors++;
    if ({m0_ready, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      miscompares++;
      $display("[TB] FAIL m0rd_resp: got ready=%b rdata=%h expected 1 deadbeef", m0_ready, m0_rdata);
    end
    vectors++;
    if ({m1_ready, m1_rdata, ce, mem_s_wstrb, mem_s_addr} !== {1'b0, 32'h0, 1'b0, 4'h0, 32'h0000_0104}) begin
      miscompares++;
      $display("[TB] FAIL m0rd_resp_side: got m1r=%b m1d=%h ce=%b ws=%h addr=%h expected 0 0 0 0 00000104",
               m1_ready, m1_rdata, ce, mem_s_wstrb, mem_s_addr);
    end
    m0_valid = 1'b0;
    tick();
    vectors++;
    if ({busy, mem_s_valid, m0_ready, mem_s_addr} !== {3'b000, 32'h0000_0104}) begin
      miscompares++;
      $display("[TB] FAIL m0rd_idle: got busy=%b v=%b r=%b addr=%h expected 0 0 0 00000104",
               busy, mem_s_valid, m0_ready, mem_s_addr);
    end
    vectors++;
    if (ce_count - c0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL m0rd_ce_cycles: got %0d expected 1", ce_count - c0);
    end
  endtask

  task automatic test_write_then_read;
    logic [31:0] rd;
    int lat, c0;
    preload(11'h004, 32'hAABBCCDD);
    c0 = ce_count;
    run_txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, lat);
    vectors++;
    if (lat !== 2 || ce_count - c0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL m1wr_timing: got lat=%0d ce=%0d expected 2 1", lat, ce_count - c0);
    end
    c0 = ce_count;
    run_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, lat);
    vectors++;
    if (rd !== 32'hAA22CC44) begin
      miscompares++;
      $display("[TB] FAIL strobe_merge: got %h expected aa22cc44", rd);
    end
    vectors++;
    if (lat !== 2 || ce_count - c0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL m0rd2_timing: got lat=%0d ce=%0d expected 2 1", lat, ce_count - c0);
    end
  endtask

  task automatic test_back_to_back;
    int rr_seq[$];
    int fp_m0_n, fp_m1_n, got;
    fp_m0_n = 0; fp_m1_n = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h4; m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (m0_ready) rr_seq.push_back(0);
      if (m1_ready) rr_seq.push_back(1);
      if (fp_m0_ready) fp_m0_n++;
      if (fp_m1_ready) fp_m1_n++;
    end
    idle_inputs();
    tick(); tick();
    vectors++;
    if (rr_seq.size() !== 8) begin
      miscompares++;
      $display("[TB] FAIL rr_count: got %0d expected 8", rr_seq.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < rr_seq.size()) ? rr_seq[i] : 9;
      vectors++;
      if (got !== (i % 2)) begin
        miscompares++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, got, i % 2);
      end
    end
    vectors++;
    if (fp_m1_n !== 8 || fp_m0_n !== 0) begin
      miscompares++;
      $display("[TB] FAIL fixed_prio: got m1=%0d m0=%0d expected 8 0", fp_m1_n, fp_m0_n);
    end
  endtask

  task automatic test_cpu_hold;
    int n0, n1;
    n0 = 0; n1 = 0;
    cpu_hold = 1'b1;
    m0_addr = 32'h0; m1_addr = 32'h4; m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (m0_ready) n0++;
      if (m1_ready) n1++;
    end
    vectors++;
    if (n0 !== 0 || n1 !== 3) begin
      miscompares++;
      $display("[TB] FAIL hold_served: got m0=%0d m1=%0d expected 0 3", n0, n1);
    end
    cpu_hold = 1'b0;
    tick();
    vectors++;
    if ({grant, ce} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL hold_release_grant: got grant=%b ce=%b expected 0 1", grant, ce);
    end
    tick();
    vectors++;
    if ({m0_ready, m1_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL hold_release_ready: got m0=%b m1=%b expected 1 0", m0_ready, m1_ready);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_access;
    m1_addr = 32'h0000_0200; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF; m1_valid = 1'b1;
    tick();
    vectors++;
    if ({ce, busy, grant} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL rst_access_entry: got ce=%b busy=%b grant=%b expected 1 1 1", ce, busy, grant);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({m1_ready, m0_ready, busy, grant, mem_s_valid, mem_s_ready} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_access_ctrl: got %b expected 000000",
               {m1_ready, m0_ready, busy, grant, mem_s_valid, mem_s_ready});
    end
    vectors++;
    if ({mem_s_addr, mem_s_wdata, mem_s_wstrb} !== 68'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_access_data: got %h/%h/%h expected 0", mem_s_addr, mem_s_wdata, mem_s_wstrb);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    vectors++;
    if ({m1_ready, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rst_no_late_ready: got ready=%b busy=%b expected 0 0", m1_ready, busy);
    end
  endtask

  task automatic test_addr_mask;
    preload(11'h7FF, 32'h600D_F00D);
    m1_addr = 32'h0000_3FFC; m1_wstrb = 4'h0; m1_valid = 1'b1;
    tick();
    vectors++;
    if ({mem_s_addr, grant} !== {32'h0000_1FFC, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL addr_mask: got addr=%h grant=%b expected 00001ffc 1", mem_s_addr, grant);
    end
    tick();
    vectors++;
    if ({m1_ready, m1_rdata, m0_ready, m0_rdata} !== {1'b1, 32'h600D_F00D, 1'b0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL addr_mask_data: got m1=%b/%h m0=%b/%h expected 1/600df00d 0/0",
               m1_ready, m1_rdata, m0_ready, m0_rdata);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    cpu_hold = 1'b0;
    idle_inputs();
    test_reset();
    test_m0_read();
    test_write_then_read();
    test_back_to_back();
    test_cpu_hold();
    test_reset_in_access();
    test_addr_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
